// File: rtl/mfrc_spi_pkg.sv
// rtl/mfrc_spi_pkg.sv - shared types and constants for the MFRC register SPI transfer engine
package mfrc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;

  // byte0 = {rw, addr, 0}; byte1 carries write data, or zeros on a read
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       rw_i,
                                                        input logic [5:0] addr_i,
                                                        input logic [7:0] wdata_i);
    logic [FRAME_BITS-1:0] f;
    f         = {1'b0, addr_i, 1'b0, (rw_i ? 8'h00 : wdata_i)};
    f[RW_BIT] = rw_i;
    return f;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SCK half-period counter producing alternating rise/fall ticks
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt;
  logic       phase;
  logic       tick;

  // A tick closes every CLK_DIV-cycle span; phase 0 means the next tick is a rising one
  assign tick = en && (cnt == 8'(CLK_DIV - 1));
  assign rise = tick && !phase;
  assign fall = tick && phase;

  // Counter and phase restart from zero whenever the engine is idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= 8'd0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mfrc_spi_xfer.sv
// rtl/mfrc_spi_xfer.sv - single 16-bit mode-0 SPI register read/write transfer engine
module mfrc_spi_xfer
  import mfrc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs
);

  state_t                state;
  state_t                state_next;
  logic                  rise;
  logic                  fall;
  logic                  load;
  logic                  finish;
  logic                  sck_up;
  logic                  sck_dn;
  logic                  rw_q;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [7:0]            rx_sr;
  logic [3:0]            bit_cnt;
  logic                  sck_q;
  logic                  cs_q;
  logic                  done_q;
  logic [7:0]            rdata_q;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state != ST_IDLE),
    .rise  (rise),
    .fall  (fall)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-cycle datapath strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    sck_up     = 1'b0;
    sck_dn     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETUP;
          load       = 1'b1;
        end
      end
      ST_SETUP: begin
        if (rise) begin
          state_next = ST_SHIFT;
          sck_up     = 1'b1;
        end
      end
      ST_SHIFT: begin
        sck_up = rise;
        sck_dn = fall;
        if (fall && (bit_cnt == 4'(FRAME_BITS - 1))) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (rise || fall) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame shifting, SCK/CS drive and read-data capture; the rx register keeps only the last 8 bits, so byte0 MISO falls out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q    <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= 8'h00;
      bit_cnt <= 4'd0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      done_q <= finish;
      if (load) begin
        cs_q    <= 1'b0;
        rw_q    <= rw;
        tx_sr   <= build_frame(rw, addr, wdata);
        rx_sr   <= 8'h00;
        bit_cnt <= 4'd0;
      end
      if (sck_up) begin
        sck_q <= 1'b1;
        rx_sr <= {rx_sr[6:0], spi_miso};
      end
      if (sck_dn) begin
        sck_q   <= 1'b0;
        tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (finish) begin
        cs_q    <= 1'b1;
        tx_sr   <= '0;
        bit_cnt <= 4'd0;
        if (rw_q) rdata_q <= rx_sr;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_sck  = sck_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = tx_sr[FRAME_BITS-1];

endmodule

// File: tb/tb_mfrc_spi_xfer.sv
// tb/tb_mfrc_spi_xfer.sv - directed bench for mfrc_spi_xfer at CLK_DIV=4 and CLK_DIV=1
module tb_mfrc_spi_xfer;

  typedef struct {
    logic        sel;
    logic        rw;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] miso_w;
    int          inject;
    logic [15:0] exp_mosi;
    int          exp_low;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rw;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       sel;
  logic       miso = 1'b0;

  logic       busy_a, done_a, sck_a, mosi_a, cs_a;
  logic [7:0] rdata_a;
  logic       busy_b, done_b, sck_b, mosi_b, cs_b;
  logic [7:0] rdata_b;

  logic       busy_m, done_m, sck_m, mosi_m, cs_m;
  logic [7:0] rdata_m;

  int checks = 0;
  int passed = 0;

  mfrc_spi_xfer #(.CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(start && !sel), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_a), .done(done_a), .rdata(rdata_a),
    .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso), .spi_cs(cs_a)
  );

  mfrc_spi_xfer #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start && sel), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_b), .done(done_b), .rdata(rdata_b),
    .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso), .spi_cs(cs_b)
  );

  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign sck_m   = sel ? sck_b   : sck_a;
  assign mosi_m  = sel ? mosi_b  : mosi_a;
  assign cs_m    = sel ? cs_b    : cs_a;
  assign rdata_m = sel ? rdata_b : rdata_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model and frame monitor, sampled on the falling clk edge
  logic [15:0] miso_word = 16'h0000;
  logic [15:0] miso_sr   = 16'h0000;
  logic [15:0] mosi_cap  = 16'h0000;
  logic        cs_prev   = 1'b1;
  logic        sck_prev  = 1'b0;
  int          cs_low_cnt = 0;
  int          last_low   = 0;
  int          gap_cnt    = 0;
  int          last_gap   = 0;
  int          done_cnt   = 0;
  int          viol       = 0;

  always @(negedge clk) begin
    if (!cs_m && cs_prev) begin
      cs_low_cnt = 1;
      mosi_cap   = 16'h0000;
      last_gap   = gap_cnt;
      miso_sr    = miso_word;
      miso       = miso_sr[15];
    end else if (!cs_m) begin
      cs_low_cnt = cs_low_cnt + 1;
    end
    if (cs_m && !cs_prev) begin
      last_low = cs_low_cnt;
      gap_cnt  = 1;
    end else if (cs_m) begin
      gap_cnt = gap_cnt + 1;
    end
    if (sck_m && !sck_prev) mosi_cap = {mosi_cap[14:0], mosi_m};
    if (!sck_m && sck_prev) begin
      miso_sr = {miso_sr[14:0], 1'b0};
      miso    = miso_sr[15];
    end
    if (done_m) done_cnt = done_cnt + 1;
    if (done_m && busy_m) viol = viol + 1;
    if (cs_m && mosi_m) viol = viol + 1;
    cs_prev  = cs_m;
    sck_prev = sck_m;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input vec_t v, input string tag);
    int  base;
    bit  got;
    base      = done_cnt;
    miso_word = v.miso_w;
    sel       = v.sel;
    rw        = v.rw;
    addr      = v.addr;
    wdata     = v.wdata;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy_after_start"}, 32'(busy_m), 32'd1);
    chk({tag, " cs_low_after_start"}, 32'(cs_m), 32'd0);
    got = 1'b0;
    for (int i = 1; i < 600 && !got; i++) begin
      if (v.inject != 0 && i == v.inject) begin
        start = 1'b1;
        rw    = ~v.rw;
        addr  = v.addr ^ 6'h2A;
        wdata = ~v.wdata;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done_m) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " rdata_in_done_cycle"}, 32'(rdata_m), 32'(v.exp_rdata));
    chk({tag, " busy_low_in_done_cycle"}, 32'(busy_m), 32'd0);
    repeat (12) tick();
    chk({tag, " mosi_frame"}, 32'(mosi_cap), 32'(v.exp_mosi));
    chk({tag, " cs_low_cycles"}, 32'(last_low), 32'(v.exp_low));
    chk({tag, " done_pulses"}, 32'(done_cnt - base), 32'd1);
    chk({tag, " idle_after"}, 32'(busy_m), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int  base;
    int  edges;
    bit  got;
    logic prev;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 6'h01, 8'h0F, 16'h5A5A, 0,  16'h020F, 132, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 6'h37, 8'h00, 16'hFF92, 0,  16'hEE00, 132, 8'h92};
    vecs[2] = '{1'b0, 1'b0, 6'h3F, 8'hC3, 16'h1234, 0,  16'h7EC3, 132, 8'h92};
    vecs[3] = '{1'b1, 1'b1, 6'h00, 8'h00, 16'h00A5, 0,  16'h8000, 33,  8'hA5};
    vecs[4] = '{1'b1, 1'b0, 6'h2A, 8'h81, 16'hFFFF, 0,  16'h5481, 33,  8'hA5};
    vecs[5] = '{1'b0, 1'b1, 6'h15, 8'h00, 16'h3C6B, 0,  16'hAA00, 132, 8'h6B};
    vecs[6] = '{1'b0, 1'b0, 6'h01, 8'h0F, 16'h0000, 20, 16'h020F, 132, 8'h6B};
    vecs[7] = '{1'b1, 1'b1, 6'h3F, 8'h00, 16'hFF00, 0,  16'hFE00, 33,  8'h00};

    reset = 1'b0;
    start = 1'b0;
    rw    = 1'b0;
    addr  = 6'h00;
    wdata = 8'h00;
    sel   = 1'b0;
    repeat (3) tick();
    chk("reset cs", 32'(cs_a), 32'd1);
    chk("reset sck", 32'(sck_a), 32'd0);
    chk("reset mosi", 32'(mosi_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset rdata", 32'(rdata_a), 32'd0);
    chk("reset cs div1", 32'(cs_b), 32'd1);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted at the 7th SCK edge of a read, checked before the next clk edge
    sel       = 1'b0;
    base      = done_cnt;
    miso_word = 16'hFF92;
    rw        = 1'b1;
    addr      = 6'h37;
    start     = 1'b1;
    tick();
    start = 1'b0;
    prev  = sck_m;
    edges = 0;
    for (int i = 0; i < 300 && edges < 7; i++) begin
      tick();
      if (sck_m != prev) edges = edges + 1;
      prev = sck_m;
    end
    chk("abort edge7 reached", 32'(edges), 32'd7);
    reset = 1'b0;
    #1;
    chk("abort cs", 32'(cs_m), 32'd1);
    chk("abort sck", 32'(sck_m), 32'd0);
    chk("abort busy", 32'(busy_m), 32'd0);
    chk("abort mosi", 32'(mosi_m), 32'd0);
    chk("abort rdata cleared", 32'(rdata_m), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (200) tick();
    chk("abort no done", 32'(done_cnt - base), 32'd0);
    v = '{1'b0, 1'b1, 6'h37, 8'h00, 16'hFF92, 0, 16'hEE00, 132, 8'h92};
    xfer(v, "post_abort");

    // start held high through done: second frame follows after a single high CS cycle
    sel       = 1'b0;
    base      = done_cnt;
    miso_word = 16'h0000;
    rw        = 1'b0;
    addr      = 6'h05;
    wdata     = 8'h33;
    start     = 1'b1;
    got       = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      tick();
      if (done_m) got = 1'b1;
    end
    chk("b2b first done", 32'(got), 32'd1);
    tick();
    chk("b2b busy next cycle", 32'(busy_m), 32'd1);
    chk("b2b cs next cycle", 32'(cs_m), 32'd0);
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      tick();
      if (done_m) got = 1'b1;
    end
    chk("b2b second done", 32'(got), 32'd1);
    repeat (12) tick();
    chk("b2b cs gap", 32'(last_gap), 32'd1);
    chk("b2b done pulses", 32'(done_cnt - base), 32'd2);
    chk("b2b mosi frame", 32'(mosi_cap), 32'h0A33);
    chk("b2b cs low cycles", 32'(last_low), 32'd132);

    chk("protocol violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
